aes_sched_ctrl: RTL
===================

Name: aes_sched_ctrl

Overview:
- Parametrised AES schedule controller: latches the key-size mode at start, drives Nk/Nr, then sequences key expansion word by word and cipher rounds 0..Nr.
- All sequencing uses valid/ready handshakes.
- Sits between the top-level command interface and the key-expansion and round datapaths.
- Key-expansion control flags (RotWord/SubWord/Rcon index) come from incremental counters; no dividers.

Parameters:
- NB, 4, state columns (words per block); fixed by FIPS-197, kept for width derivation.
- RND_W, 4, width of round counter and Nk/Nr outputs; must hold 14.
- IDX_W, 6, width of key-word index; must hold NB*(14+1)-1 = 59.
- RCON_W, 4, width of Rcon index; must hold 10.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; accepted only in IDLE.
- sel_i  in  2  mode: 00 AES-128, 01 AES-192, 10 AES-256, 11 invalid.
- key_ready_i  in  1  key datapath accepts current word.
- round_ready_i  in  1  round datapath accepts current round.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  one-cycle pulse when start_i is seen with sel_i = 11.
- nk_o  out  RND_W  latched Nk (4/6/8).
- nr_o  out  RND_W  latched Nr (10/12/14).
- key_word_en_o  out  1  key word valid (state KEYEXP).
- key_word_idx_o  out  IDX_W  current word index i.
- key_rot_o  out  1  i mod Nk == 0: apply RotWord+SubWord+Rcon.
- key_sub_o  out  1  Nk == 8 and i mod Nk == 4: SubWord only.
- rcon_idx_o  out  RCON_W  i/Nk; valid when key_rot_o = 1.
- round_en_o  out  1  round valid (state ROUNDS).
- round_o  out  RND_W  current round number.
- first_round_o  out  1  round_o == 0 (AddRoundKey only).
- last_round_o  out  1  round_o == Nr (no MixColumns).
- done_o  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including nk_o, nr_o, indices and counters.
- States: IDLE, KEYEXP, ROUNDS, DONE. All outputs are registered or decoded from state and registers only; no combinational input-to-output paths.
- IDLE:
  - start_i with valid sel_i: latch Nk/Nr (128: 4/10, 192: 6/12, 256: 8/14).
  - Load key_word_idx = Nk, mod-Nk counter = 0, rcon = 1.
  - Enter KEYEXP next cycle.
- Invalid start: start_i with sel_i = 11 asserts err_o the next cycle for 1 cycle; remain IDLE; nk_o/nr_o unchanged.
- Start while busy: start_i and sel_i are ignored when not IDLE; the latched mode holds for the whole operation.
- KEYEXP:
  - key_word_en_o = 1.
  - Advance only on key_word_en_o & key_ready_i: idx+1; mod counter wraps Nk-1 -> 0; rcon increments on each wrap.
  - key_ready_i low: all key outputs hold stable.
  - Handshake on idx == NB*(Nr+1)-1: go to ROUNDS with round = 0.
- Word counts: AES-128 words 4..43 (40); AES-192 words 6..51 (46); AES-256 words 8..59 (52).
- ROUNDS:
  - round_en_o = 1.
  - Advance on round_en_o & round_ready_i.
  - Handshake with round == Nr: go to DONE.
  - Total Nr+1 handshakes.
- DONE: done_o = 1 and busy_o = 1 for exactly one cycle; then IDLE. nk_o/nr_o retain the last mode.
- Minimum latency (ready inputs tied high), start accepted at cycle T: done_o at T + 1 + words + (Nr+1). AES-128: T+52.
- Reset mid-operation: immediate return to IDLE and reset values; no done_o or err_o pulse.

Test Plan:
- AES-128, readies high, start at T: 40 key words, idx 4..43; key_rot_o at i = 4, 8, .., 40 with rcon 1..10; key_sub_o never set; rounds 0..10 with first_round_o at 0 and last_round_o at 10; done_o at T+52.
- AES-192: idx 6..51; key_rot_o at 6, 12, .., 48 (rcon 1..8); nr_o = 12; 13 round handshakes; done_o at T+60.
- AES-256: idx 8..59; key_rot_o at 8, 16, .., 56 (rcon 1..7); key_sub_o at 12, 20, .., 52; rounds 0..14; done_o at T+68.
- Backpressure: key_ready_i low for 3 cycles at idx 20 and round_ready_i low for 2 cycles at round 5 -> outputs hold; total latency grows by exactly 5.
- start_i with sel_i = 11 -> err_o pulses for 1 cycle; busy_o stays 0. start_i with sel_i = 10 while busy in AES-128 -> ignored; nr_o stays 10.
- rst_ni asserted during KEYEXP at idx 30 -> all outputs 0 asynchronously. A following AES-128 start completes normally with 40 words.

Source files
------------

// File: rtl/aes_sched_ctrl.sv
// AES schedule controller.
// Latches the key-size mode when a start is accepted and drives Nk/Nr from
// that latched mode. It then steps through key expansion one word at a time,
// followed by the cipher rounds 0..Nr. Each step advances only on a
// valid/ready handshake with the key-expansion or round datapath.
// All outputs are either registers or decodes of state and registers, so no
// input reaches an output without passing through a flop.
module aes_sched_ctrl #(
  parameter int NB     = 4,  // state columns, FIPS-197 fixed
  parameter int RND_W  = 4,  // round counter / Nk / Nr width, holds 14
  parameter int IDX_W  = 6,  // key-word index width, holds 59
  parameter int RCON_W = 4   // Rcon index width, holds 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        sel_i,
  input  logic              key_ready_i,
  input  logic              round_ready_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [RND_W-1:0]  nk_o,
  output logic [RND_W-1:0]  nr_o,
  output logic              key_word_en_o,
  output logic [IDX_W-1:0]  key_word_idx_o,
  output logic              key_rot_o,
  output logic              key_sub_o,
  output logic [RCON_W-1:0] rcon_idx_o,
  output logic              round_en_o,
  output logic [RND_W-1:0]  round_o,
  output logic              first_round_o,
  output logic              last_round_o,
  output logic              done_o
);

  // Sequencer states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_KEYEXP = 2'd1;
  localparam logic [1:0] ST_ROUNDS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Mode select encodings.
  localparam logic [1:0] SEL_128 = 2'b00;
  localparam logic [1:0] SEL_192 = 2'b01;
  localparam logic [1:0] SEL_256 = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [RND_W-1:0]  nk_q, nr_q;
  logic [IDX_W-1:0]  last_idx_q;   // NB*(Nr+1)-1, latched with the mode
  logic [IDX_W-1:0]  idx_q;
  logic [RND_W-1:0]  mod_q;        // runs as idx mod Nk, without a divider
  logic [RCON_W-1:0] rcon_q;       // runs as idx / Nk, bumped on each mod wrap
  logic [RND_W-1:0]  round_q;
  logic              err_q;

  // Mode table lookup for the current sel_i.
  logic [RND_W-1:0]  mode_nk, mode_nr;
  logic [IDX_W-1:0]  mode_last;

  // Handshake qualifiers.
  logic start_ok, start_bad;
  logic key_hs, key_last;
  logic round_hs, round_last;
  logic mod_wrap;

  assign start_ok   = (state_q == ST_IDLE) && start_i && (sel_i != SEL_BAD);
  assign start_bad  = (state_q == ST_IDLE) && start_i && (sel_i == SEL_BAD);
  assign key_hs     = (state_q == ST_KEYEXP) && key_ready_i;
  assign key_last   = key_hs && (idx_q == last_idx_q);
  assign round_hs   = (state_q == ST_ROUNDS) && round_ready_i;
  assign round_last = round_hs && (round_q == nr_q);
  assign mod_wrap   = (mod_q == (nk_q - RND_W'(1)));

  // Decode Nk, Nr and the final key-word index for the requested key size.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    mode_nk   = RND_W'(4);
    mode_nr   = RND_W'(10);
    mode_last = IDX_W'(NB * (10 + 1) - 1);
    case (sel_i)
      SEL_192: begin
        mode_nk   = RND_W'(6);
        mode_nr   = RND_W'(12);
        mode_last = IDX_W'(NB * (12 + 1) - 1);
      end
      SEL_256: begin
        mode_nk   = RND_W'(8);
        mode_nr   = RND_W'(14);
        mode_last = IDX_W'(NB * (14 + 1) - 1);
      end
      default: ;
    endcase
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok)   state_d = ST_KEYEXP;
      ST_KEYEXP: if (key_last)   state_d = ST_ROUNDS;
      ST_ROUNDS: if (round_last) state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of block evaluation order.
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Latch the mode on an accepted start; it holds through DONE and beyond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nk_q       <= '0;
      nr_q       <= '0;
      last_idx_q <= '0;
    end else if (start_ok) begin
      nk_q       <= mode_nk;
      nr_q       <= mode_nr;
      last_idx_q <= mode_last;
    end
  end

  // Key-word index, mod-Nk counter and Rcon index, advanced per key handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      mod_q  <= '0;
      rcon_q <= '0;
    end else if (start_ok) begin
      idx_q  <= IDX_W'(mode_nk);
      mod_q  <= '0;
      rcon_q <= RCON_W'(1);
    end else if (key_hs && !key_last) begin
      idx_q <= idx_q + IDX_W'(1);
      if (mod_wrap) begin
        mod_q  <= '0;
        rcon_q <= rcon_q + RCON_W'(1);
      end else begin
        mod_q  <= mod_q + RND_W'(1);
      end
    end
  end

  // Round counter: cleared on entry to ROUNDS, advanced per round handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      round_q <= '0;
    end else if (start_ok || key_last) begin
      round_q <= '0;
    end else if (round_hs && !round_last) begin
      round_q <= round_q + RND_W'(1);
    end
  end

  // Error flag: a one-cycle pulse following a start with the invalid mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= start_bad;
  end

  // Output decode from state and registers only.
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;
  assign nk_o           = nk_q;
  assign nr_o           = nr_q;
  assign key_word_en_o  = (state_q == ST_KEYEXP);
  assign key_word_idx_o = idx_q;
  assign key_rot_o      = key_word_en_o && (mod_q == '0);
  assign key_sub_o      = key_word_en_o && (nk_q == RND_W'(8)) && (mod_q == RND_W'(4));
  assign rcon_idx_o     = rcon_q;
  assign round_en_o     = (state_q == ST_ROUNDS);
  assign round_o        = round_q;
  assign first_round_o  = round_en_o && (round_q == '0);
  assign last_round_o   = round_en_o && (round_q == nr_q);
  assign done_o         = (state_q == ST_DONE);

endmodule
